// File: rtl/button_cond_st.sv
// rtl/button_cond_st.sv - push-button synchronizer, debouncer and press-strobe generator
//
// Purpose: conditions the raw surgeon push-button for the laser controller.
//   The asynchronous input is passed through a two-flop synchronizer. A
//   four-state FSM with an NBITS-wide counter then accepts a level change
//   only after the synchronized input has held the new level for
//   DB_CYCLES+1 consecutive edges.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   b        in   raw asynchronous button (1 = pressed)
//   b_db     out  debounced level, registered
//   b_pulse  out  one-cycle strobe per accepted press, registered
//   state_o  out  FSM state (00 IDLE, 01 PRESS_CHK, 10 PRESSED, 11 RELEASE_CHK)

module button_cond_st #(
  parameter int NBITS     = 16,
  parameter int DB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b,
  output logic       b_db,
  output logic       b_pulse,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PRESS_CHK   = 2'b01,
    PRESSED     = 2'b10,
    RELEASE_CHK = 2'b11
  } state_t;

  // Terminal count of a check window. Leaving at DB_CYCLES-1 keeps the
  // counter from ever wrapping.
  localparam logic [NBITS-1:0] LP_LAST = NBITS'(DB_CYCLES - 1);

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic [NBITS-1:0] r_cnt;
  logic             r_b_db;
  logic             r_b_pulse;
  logic             w_b_s;

  // Only the second synchronizer stage is allowed into the FSM.
  assign w_b_s = r_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_cnt     <= '0;
      r_state   <= IDLE;
      r_b_db    <= 1'b0;
      r_b_pulse <= 1'b0;
    end else begin
      r_s1      <= b;
      r_s2      <= r_s1;
      r_b_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          r_b_db <= 1'b0;
          if (w_b_s) begin
            r_state <= PRESS_CHK;
            r_cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          r_b_db <= 1'b0;
          if (!w_b_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            // Only place a strobe is born; it lines up with b_db rising.
            r_state   <= PRESSED;
            r_cnt     <= '0;
            r_b_db    <= 1'b1;
            r_b_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          r_b_db <= 1'b1;
          if (!w_b_s) begin
            r_state <= RELEASE_CHK;
            r_cnt   <= '0;
          end
        end
        RELEASE_CHK: begin
          r_b_db <= 1'b1;
          if (w_b_s) begin
            // Release bounce: fall back to PRESSED without a new strobe.
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_b_db  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_b_db  <= 1'b0;
        end
      endcase
    end
  end

  assign b_db    = r_b_db;
  assign b_pulse = r_b_pulse;
  assign state_o = r_state;

endmodule

// File: tb/tb_button_cond_st.sv
// tb/tb_button_cond_st.sv - self-checking bench for button_cond_st

module tb_button_cond_st;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b = 1'b0;
  logic       b_db4, b_pulse4;
  logic [1:0] state4;
  logic       b_db1, b_pulse1;
  logic [1:0] state1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_cond_st #(.NBITS(16), .DB_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .b(b),
    .b_db(b_db4), .b_pulse(b_pulse4), .state_o(state4)
  );

  button_cond_st #(.NBITS(16), .DB_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .b(b),
    .b_db(b_db1), .b_pulse(b_pulse1), .state_o(state1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: a level change is accepted once the synchronized input
  // has disagreed with the accepted level for DB+1 consecutive edges; any
  // agreeing edge restarts the run. The reported state is the accepted
  // level plus a flag saying a run is in progress.
  int   dbc [2] = '{4, 1};
  logic m_s1 = 1'b0, m_s2 = 1'b0;
  int   run_m [2] = '{0, 0};
  logic db_m [2] = '{1'b0, 1'b0};
  logic pulse_m [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      for (int k = 0; k < 2; k++) begin
        run_m[k]   = 0;
        db_m[k]    = 1'b0;
        pulse_m[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        pulse_m[k] = 1'b0;
        if (m_s2 != db_m[k]) begin
          run_m[k]++;
          if (run_m[k] == dbc[k] + 1) begin
            db_m[k]    = ~db_m[k];
            pulse_m[k] = db_m[k];
            run_m[k]   = 0;
          end
        end else begin
          run_m[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  end

  // Continuous comparison against the model plus the strobe spacing guarantee.
  int cyc = 0;
  int last_pulse = -1;

  always @(negedge clk) begin
    cyc++;
    check("db4", 32'(b_db4), 32'(db_m[0]));
    check("pulse4", 32'(b_pulse4), 32'(pulse_m[0]));
    check("state4", 32'(state4), 32'({db_m[0], run_m[0] != 0}));
    check("db1", 32'(b_db1), 32'(db_m[1]));
    check("pulse1", 32'(b_pulse1), 32'(pulse_m[1]));
    check("state1", 32'(state1), 32'({db_m[1], run_m[1] != 0}));
    if (reset) begin
      last_pulse = -1;
    end else if (b_pulse4) begin
      if (last_pulse >= 0)
        check("pulse_gap_ok", 32'((cyc - last_pulse) >= 10), 32'd1);
      last_pulse = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int pc;

  initial begin
    // 1: reset held with the button pressed, then a full press debounce.
    b = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_db", 32'(b_db4), 32'd0);
      check("rst_pulse", 32'(b_pulse4), 32'd0);
      check("rst_state", 32'(state4), 32'd0);
    end
    reset = 1'b0;
    pc = 0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (b_pulse4) pc++;
      if (e == 6) check("rst_pulse_e6", 32'(b_pulse4), 32'd1);
    end
    check("rst_pulse_cnt", 32'(pc), 32'd1);

    // 2: clean press from idle.
    b = 1'b0;
    repeat (20) tick();
    check("idle_state", 32'(state4), 32'd0);
    b = 1'b1;
    pc = 0;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (b_pulse4) pc++;
      if (e == 1) check("clean_st_e1", 32'(state4), 32'd0);
      if (e == 2) check("clean_st_e2", 32'(state4), 32'd1);
      if (e == 5) check("clean_st_e5", 32'(state4), 32'd1);
      if (e == 5) check("clean_db_e5", 32'(b_db4), 32'd0);
      if (e == 6) check("clean_st_e6", 32'(state4), 32'd2);
      if (e == 6) check("clean_db_e6", 32'(b_db4), 32'd1);
      if (e == 6) check("clean_pulse_e6", 32'(b_pulse4), 32'd1);
      if (e == 7) check("clean_pulse_e7", 32'(b_pulse4), 32'd0);
    end
    check("held_pulse_cnt", 32'(pc), 32'd1);
    check("held_db", 32'(b_db4), 32'd1);

    // 5: release bounce, then final release.
    pc = 0;
    b = 1'b0; tick(); tick();
    b = 1'b1; repeat (3) tick();
    check("relb_db_mid", 32'(b_db4), 32'd1);
    b = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (b_pulse4) pc++;
      if (e == 5) check("relb_db_e5", 32'(b_db4), 32'd1);
      if (e == 6) check("relb_db_e6", 32'(b_db4), 32'd0);
    end
    check("relb_pulse_cnt", 32'(pc), 32'd0);

    // 3: bouncy press, then held.
    pc = 0;
    b = 1'b1; tick();
    b = 1'b0; tick();
    b = 1'b1; tick();
    b = 1'b0; tick();
    b = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      tick();
      if (b_pulse4) pc++;
      if (e < 6) check("bounce_nopulse", 32'(b_pulse4), 32'd0);
      if (e == 6) check("bounce_pulse_e6", 32'(b_pulse4), 32'd1);
    end
    check("bounce_pulse_cnt", 32'(pc), 32'd1);

    // 4: short glitch from idle.
    b = 1'b0;
    repeat (15) tick();
    pc = 0;
    b = 1'b1; repeat (3) tick();
    b = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (b_pulse4) pc++;
      check("glitch_db", 32'(b_db4), 32'd0);
    end
    check("glitch_pulse_cnt", 32'(pc), 32'd0);
    check("glitch_state", 32'(state4), 32'd0);

    // 6: reset while PRESS_CHK count is 2.
    b = 1'b1;
    for (int e = 0; e <= 4; e++) tick();
    check("pc_state_pre", 32'(state4), 32'd1);
    check("pc_cnt_pre", 32'(dut4.r_cnt), 32'd2);
    reset = 1'b1;
    tick();
    check("pc_rst_state", 32'(state4), 32'd0);
    check("pc_rst_cnt", 32'(dut4.r_cnt), 32'd0);
    check("pc_rst_db", 32'(b_db4), 32'd0);
    check("pc_rst_pulse", 32'(b_pulse4), 32'd0);
    reset = 1'b0;
    b = 1'b0;
    repeat (15) tick();

    // Randomized phase: random hold lengths and occasional resets.
    for (int i = 0; i < 400; i++) begin
      b = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 49) == 0);
      tick();
      reset = 1'b0;
      repeat ($urandom_range(0, 11)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
